// File: rtl/hazard_sched.sv
// hazard_sched: front-end hazard scheduler for the IF/ID and ID/EX registers.
// Resolves data-memory wait, mispredict redirect, load-use and fetch miss in
// strict priority each cycle. All control outputs are combinational.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/redirect perf counters;
// when undefined both counter ports read 0.
module hazard_sched #(
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic        id_need_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_need_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rds,
  input  logic        ex_is_load,
  input  logic        ex_mispredict,
  input  logic        mem_busy,
  input  logic        ifetch_busy,
  output logic        pc_we,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_redir_cnt
);

  localparam int unsigned RcW  = 3;
  localparam int unsigned RegW = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    REDIR  = 2'd2,
    MWAIT  = 2'd3
  } state_t;

  state_t         curState;
  state_t         nextState;
  logic [RcW-1:0] rc;
  logic [RcW-1:0] rcNext;
  logic           loadUse;
  logic           inRedirect;

  // Load-use: consumer in IF/ID reads the destination of a load in ID/EX (r0 never hazards)
  always_comb begin
    loadUse = id_valid && ex_valid && ex_is_load && (ex_rds != RegW'(0)) &&
              ((id_need_rs1 && (id_rs1 == ex_rds)) ||
               (id_need_rs2 && (id_rs2 == ex_rds)));
  end

  // Redirect in progress, including one paused by a memory wait
  always_comb begin
    inRedirect = (curState == REDIR) || ((curState == MWAIT) && (rc != RcW'(0)));
  end

  // State and redirect-counter registers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      curState <= RUN;
      rc       <= '0;
    end else begin
      curState <= nextState;
      rc       <= rcNext;
    end
  end

  // Priority resolution: next state, counter update and pipeline controls
  always_comb begin
    nextState  = RUN;
    rcNext     = rc;
    pc_we      = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    if (!reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      rcNext     = '0;
    end else if (mem_busy) begin
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      nextState  = MWAIT;
    end else if (ex_mispredict && ex_valid) begin
      pc_we      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      rcNext     = RcW'(REDIRECT_BUBBLES);
      nextState  = (REDIRECT_BUBBLES != 0) ? REDIR : RUN;
    end else if (inRedirect) begin
      pc_we      = 1'b1;
      ifid_flush = 1'b1;
      if (rc != RcW'(0)) begin
        rcNext = rc - RcW'(1);
      end
      nextState  = (rc <= RcW'(1)) ? RUN : REDIR;
    end else if (loadUse) begin
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      nextState  = BUBBLE;
    end else if (ifetch_busy) begin
      ifid_flush = 1'b1;
    end else begin
      pc_we      = 1'b1;
    end
  end

  assign state = curState;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [31:0] redirCnt;
  logic        redirFire;

  assign redirFire = reset && !mem_busy && ex_mispredict && ex_valid;

  // Free-running wrap-around performance counters
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      redirCnt <= '0;
    end else begin
      if (!pc_we) begin
        stallCnt <= stallCnt + 32'd1;
      end
      if (redirFire) begin
        redirCnt <= redirCnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stallCnt;
  assign perf_redir_cnt = redirCnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed self-checking bench for hazard_sched (REDIRECT_BUBBLES=2).
module tb_hazard_sched;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        reset;
  logic        id_valid, id_need_rs1, id_need_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rds;
  logic        ex_valid, ex_is_load, ex_mispredict, mem_busy, ifetch_busy;
  logic        pc_we, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic [1:0]  state;
  logic [31:0] perf_stall_cnt, perf_redir_cnt;

  logic [4:0]  ctl;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] expStall = 0;
  logic [31:0] expRedir = 0;

  assign ctl = {pc_we, ifid_stall, ifid_flush, idex_stall, idex_flush};

  always #5 Clk = ~Clk;

  hazard_sched #(.REDIRECT_BUBBLES(2)) dut (
    .Clk(Clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_need_rs1(id_need_rs1),
    .id_rs2(id_rs2), .id_need_rs2(id_need_rs2),
    .ex_valid(ex_valid), .ex_rds(ex_rds), .ex_is_load(ex_is_load),
    .ex_mispredict(ex_mispredict), .mem_busy(mem_busy), .ifetch_busy(ifetch_busy),
    .pc_we(pc_we), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .state(state),
    .perf_stall_cnt(perf_stall_cnt), .perf_redir_cnt(perf_redir_cnt)
  );

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic setIdle();
    id_valid = 0; id_rs1 = 0; id_need_rs1 = 0; id_rs2 = 0; id_need_rs2 = 0;
    ex_valid = 0; ex_rds = 0; ex_is_load = 0; ex_mispredict = 0;
    mem_busy = 0; ifetch_busy = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    setIdle();
    repeat (3) nextCycle();
    #2;
    checks++;
    if ({ctl, state} !== {5'b00101, 2'd0}) begin
      errors++; $display("FAIL in_reset ctl/state got %b/%0d want 00101/0", ctl, state);
    end
    reset = 1;
    #2;
    checks++;
    if ({ctl, state} !== {5'b10000, 2'd0}) begin
      errors++; $display("FAIL reset_release ctl/state got %b/%0d want 10000/0", ctl, state);
    end
    checks++;
    if ({perf_stall_cnt, perf_redir_cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", perf_stall_cnt, perf_redir_cnt);
    end
    nextCycle();
  endtask

  task automatic test_load_use();
    id_valid = 1; id_need_rs1 = 1; id_rs1 = 3; id_need_rs2 = 1; id_rs2 = 5;
    ex_valid = 1; ex_is_load = 1; ex_rds = 5;
    #2;
    checks++;
    if ({ctl, state} !== {5'b01001, 2'd0}) begin
      errors++; $display("FAIL lu_rs2 ctl/state got %b/%0d want 01001/0", ctl, state);
    end
    nextCycle(); expStall++;
    ex_valid = 0;
    #2;
    checks++;
    if ({ctl, state} !== {5'b10000, 2'd1}) begin
      errors++; $display("FAIL lu_bubble ctl/state got %b/%0d want 10000/1", ctl, state);
    end
    nextCycle();
    #2;
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL lu_back_to_run state got %0d want 0", state);
    end
    ex_valid = 1; ex_rds = 0; id_rs1 = 0; id_rs2 = 0;
    #2;
    checks++;
    if (ctl !== 5'b10000) begin
      errors++; $display("FAIL lu_r0 ctl got %b want 10000", ctl);
    end
    ex_rds = 5; id_rs1 = 3; id_rs2 = 5; id_need_rs2 = 0;
    #2;
    checks++;
    if (ctl !== 5'b10000) begin
      errors++; $display("FAIL lu_need_off ctl got %b want 10000", ctl);
    end
    id_rs1 = 5;
    #2;
    checks++;
    if (ctl !== 5'b01001) begin
      errors++; $display("FAIL lu_rs1 ctl got %b want 01001", ctl);
    end
    setIdle();
    nextCycle();
  endtask

  task automatic test_mispredict();
    ex_valid = 1; ex_mispredict = 1;
    #2;
    checks++;
    if ({ctl, state} !== {5'b10101, 2'd0}) begin
      errors++; $display("FAIL mp_cycle0 ctl/state got %b/%0d want 10101/0", ctl, state);
    end
    nextCycle(); expRedir++;
    setIdle();
    for (int i = 1; i <= 2; i++) begin
      #2;
      checks++;
      if ({ctl, state} !== {5'b10100, 2'd2}) begin
        errors++; $display("FAIL mp_redir%0d ctl/state got %b/%0d want 10100/2", i, ctl, state);
      end
      nextCycle();
    end
    #2;
    checks++;
    if ({ctl, state} !== {5'b10000, 2'd0}) begin
      errors++; $display("FAIL mp_cycle3 ctl/state got %b/%0d want 10000/0", ctl, state);
    end
    checks++;
    if (perf_redir_cnt !== (PerfEn ? expRedir : 32'd0)) begin
      errors++; $display("FAIL mp_redir_cnt got %0d want %0d", perf_redir_cnt, PerfEn ? expRedir : 32'd0);
    end
  endtask

  task automatic test_mem_wait_redir();
    ex_valid = 1; ex_mispredict = 1;
    nextCycle(); expRedir++;
    setIdle();
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if ({ctl, state} !== {5'b01010, (i == 0) ? 2'd2 : 2'd3}) begin
        errors++; $display("FAIL mw_hold%0d ctl/state got %b/%0d want 01010/%0d", i, ctl, state, (i == 0) ? 2 : 3);
      end
      nextCycle(); expStall++;
    end
    mem_busy = 0;
    #2;
    checks++;
    if ({ctl, state} !== {5'b10100, 2'd3}) begin
      errors++; $display("FAIL mw_resume ctl/state got %b/%0d want 10100/3", ctl, state);
    end
    nextCycle();
    #2;
    checks++;
    if ({ctl, state} !== {5'b10100, 2'd2}) begin
      errors++; $display("FAIL mw_redir_last ctl/state got %b/%0d want 10100/2", ctl, state);
    end
    nextCycle();
    #2;
    checks++;
    if ({ctl, state} !== {5'b10000, 2'd0}) begin
      errors++; $display("FAIL mw_done ctl/state got %b/%0d want 10000/0", ctl, state);
    end
  endtask

  task automatic test_same_cycle();
    mem_busy = 1; ex_valid = 1; ex_mispredict = 1; ex_is_load = 1; ex_rds = 7;
    id_valid = 1; id_need_rs1 = 1; id_rs1 = 7;
    #2;
    checks++;
    if ({ctl, state} !== {5'b01010, 2'd0}) begin
      errors++; $display("FAIL same_membusy ctl/state got %b/%0d want 01010/0", ctl, state);
    end
    nextCycle(); expStall++;
    #2;
    checks++;
    if ({ctl, state} !== {5'b01010, 2'd3}) begin
      errors++; $display("FAIL same_mwait ctl/state got %b/%0d want 01010/3", ctl, state);
    end
    mem_busy = 0;
    #2;
    checks++;
    if ({ctl, state} !== {5'b10101, 2'd3}) begin
      errors++; $display("FAIL same_accept ctl/state got %b/%0d want 10101/3", ctl, state);
    end
    nextCycle(); expRedir++;
    setIdle();
    #2;
    checks++;
    if ({ctl, state} !== {5'b10100, 2'd2}) begin
      errors++; $display("FAIL same_redir ctl/state got %b/%0d want 10100/2", ctl, state);
    end
    repeat (2) nextCycle();
    #2;
    checks++;
    if ({ctl, state} !== {5'b10000, 2'd0}) begin
      errors++; $display("FAIL same_done ctl/state got %b/%0d want 10000/0", ctl, state);
    end
    checks++;
    if (perf_redir_cnt !== (PerfEn ? expRedir : 32'd0)) begin
      errors++; $display("FAIL same_redir_cnt got %0d want %0d", perf_redir_cnt, PerfEn ? expRedir : 32'd0);
    end
  endtask

  task automatic test_fetch_miss();
    ifetch_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({ctl, state} !== {5'b00100, 2'd0}) begin
        errors++; $display("FAIL fm_cycle%0d ctl/state got %b/%0d want 00100/0", i, ctl, state);
      end
      nextCycle(); expStall++;
    end
    ifetch_busy = 0;
    #2;
    checks++;
    if (perf_stall_cnt !== (PerfEn ? expStall : 32'd0)) begin
      errors++; $display("FAIL fm_stall_cnt got %0d want %0d", perf_stall_cnt, PerfEn ? expStall : 32'd0);
    end
`ifdef HAZARD_PERF_CNT_EN
    dut.stallCnt = 32'hFFFF_FFFF;
`endif
    ifetch_busy = 1;
    nextCycle();
    ifetch_busy = 0;
    #2;
    checks++;
    if (perf_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL fm_wrap got %0h want 0", perf_stall_cnt);
    end
  endtask

  task automatic test_reset_mid_redirect();
    ex_valid = 1; ex_mispredict = 1;
    nextCycle();
    setIdle();
    #2;
    checks++;
    if (state !== 2'd2) begin
      errors++; $display("FAIL rmid_redir state got %0d want 2", state);
    end
    reset = 0;
    #2;
    checks++;
    if ({ctl, state} !== {5'b00101, 2'd0}) begin
      errors++; $display("FAIL rmid_in_reset ctl/state got %b/%0d want 00101/0", ctl, state);
    end
    nextCycle();
    reset = 1;
    #2;
    checks++;
    if ({ctl, state} !== {5'b10000, 2'd0}) begin
      errors++; $display("FAIL rmid_discard ctl/state got %b/%0d want 10000/0", ctl, state);
    end
    checks++;
    if ({perf_stall_cnt, perf_redir_cnt} !== 64'd0) begin
      errors++; $display("FAIL rmid_counters got %0d/%0d want 0/0", perf_stall_cnt, perf_redir_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_wait_redir();
    test_same_cycle();
    test_fetch_miss();
    test_reset_mid_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
